// File: rtl/ux607_ilm_ram_ctrl.sv
// ILM SRAM initiator: valid/ready command/response front end, registered SRAM
// strobes, in-order 2-entry response buffer and light-sleep/shutdown sequencing.
module ux607_ilm_ram_ctrl #(
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 64,
    parameter int unsigned MW          = 8,
    parameter int unsigned LS_IDLE_CYC = 16,
    parameter int unsigned SD_WAKE_CYC = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_read,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [MW-1:0] cmd_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    input  logic          sd_req,
    output logic          idle,
    output logic          ram_cs,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls,
    output logic          ram_ds,
    output logic          ram_sd
);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_LS     = 2'd1;
    localparam logic [1:0] ST_SD     = 2'd2;
    localparam logic [1:0] ST_WAKE   = 2'd3;

    localparam int unsigned ICW = (LS_IDLE_CYC > 1) ? $clog2(LS_IDLE_CYC) : 1;
    localparam int unsigned WCW = $clog2(SD_WAKE_CYC + 1);

    logic [1:0]     state_q, state_d;
    logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
    logic [WCW-1:0] wake_cnt_q, wake_cnt_d;

    logic           cs_rd_q;
    logic           inflight_q;
    logic           inflight_rd_q;

    logic [DW-1:0]  buf_data [2];
    logic           wr_ptr, rd_ptr;
    logic [1:0]     buf_cnt;

    logic [1:0]     occ;
    logic           accept;
    logic           buf_empty;
    logic           push_buf, pop_buf;
    logic [DW-1:0]  inflight_data;

    assign occ       = buf_cnt + {1'b0, ram_cs} + {1'b0, inflight_q};
    assign cmd_ready = rst_n & (state_q == ST_ACTIVE) & (occ < 2'd2) & ~sd_req;
    assign accept    = cmd_valid & cmd_ready;
    assign buf_empty = (buf_cnt == 2'd0);
    assign idle      = ~ram_cs & ~inflight_q & buf_empty;

    assign inflight_data = inflight_rd_q ? ram_dout : '0;

    // The inflight slot acts as the buffer tail: with the buffer empty its data is
    // presented directly, and it is only written into storage if not taken now.
    assign rsp_valid = ~buf_empty | inflight_q;
    assign rsp_rdata = ~buf_empty ? buf_data[rd_ptr] :
                       (inflight_q ? inflight_data : '0);
    assign pop_buf   = rsp_ready & ~buf_empty;
    assign push_buf  = inflight_q & ~(buf_empty & rsp_ready);

    assign ram_ls = (state_q == ST_LS);
    assign ram_sd = (state_q == ST_SD);
    assign ram_ds = 1'b0;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_ACTIVE: begin
                idle_cnt_d = (idle & ~cmd_valid) ? idle_cnt_q + 1'b1 : '0;
                if (sd_req & idle) begin
                    state_d    = ST_SD;
                    idle_cnt_d = '0;
                end else if (idle & ~cmd_valid &
                             (idle_cnt_q == ICW'(LS_IDLE_CYC - 1))) begin
                    state_d    = ST_LS;
                    idle_cnt_d = '0;
                end
            end
            ST_LS: begin
                if (sd_req) begin
                    state_d = ST_SD;
                end else if (cmd_valid) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = WCW'(1);
                end
            end
            ST_SD: begin
                if (~sd_req) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = WCW'(SD_WAKE_CYC);
                end
            end
            ST_WAKE: begin
                if (sd_req) begin
                    state_d = ST_SD;
                end else if (wake_cnt_q <= WCW'(1)) begin
                    state_d    = ST_ACTIVE;
                    idle_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d    = ST_ACTIVE;
                idle_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_ACTIVE;
            idle_cnt_q    <= '0;
            wake_cnt_q    <= '0;
            ram_cs        <= 1'b0;
            ram_addr      <= '0;
            ram_wem       <= '0;
            ram_din       <= '0;
            cs_rd_q       <= 1'b0;
            inflight_q    <= 1'b0;
            inflight_rd_q <= 1'b0;
            buf_data[0]   <= '0;
            buf_data[1]   <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            buf_cnt       <= 2'd0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;

            ram_cs <= accept;
            if (accept) begin
                ram_addr <= cmd_addr;
                ram_din  <= cmd_wdata;
                ram_wem  <= cmd_read ? '0 : cmd_wmask;
                cs_rd_q  <= cmd_read;
            end else begin
                ram_wem  <= '0;
            end

            inflight_q    <= ram_cs;
            inflight_rd_q <= ram_cs & cs_rd_q;

            if (push_buf) begin
                buf_data[wr_ptr] <= inflight_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_buf) begin
                rd_ptr <= ~rd_ptr;
            end
            buf_cnt <= buf_cnt + {1'b0, push_buf} - {1'b0, pop_buf};
        end
    end

endmodule

// File: tb/tb_ux607_ilm_ram_ctrl.sv
// Bench for ux607_ilm_ram_ctrl: directed steps plus random traffic checked against
// an in-order response scoreboard and a byte-masked memory model.
module tb_ux607_ilm_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_wmask;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_rdata;
    logic        sd_req, idle;
    logic        ram_cs;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wem;
    logic [63:0] ram_din, ram_dout;
    logic        ram_ls, ram_ds, ram_sd;

    always #5 clk = ~clk;

    ux607_ilm_ram_ctrl #(
        .AW(16), .DW(64), .MW(8), .LS_IDLE_CYC(16), .SD_WAKE_CYC(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .sd_req(sd_req), .idle(idle),
        .ram_cs(ram_cs), .ram_addr(ram_addr), .ram_wem(ram_wem), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
    );

    typedef struct {
        logic [63:0] data;
        int unsigned avail;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [63:0] ref_mem [256];
    logic [63:0] sram    [256];
    int unsigned n_cmp = 0, n_err = 0, cyc_no = 0;

    bit          pend_cs;
    logic [15:0] pend_addr;
    logic [7:0]  pend_wem;
    logic [63:0] pend_din;
    bit          chk_on, chk_ready;
    bit          last_acc, m_idle;
    logic        obs_ls, obs_sd, obs_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++)
            if (m[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    // One clock: check at the falling edge, update models, advance past the rising edge.
    task automatic cyc();
        bit          acc, exp_valid;
        logic [63:0] nx_dout;
        @(negedge clk);
        nx_dout   = ram_dout;
        acc       = (rst_n === 1'b1) && (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
        obs_ls    = ram_ls;
        obs_sd    = ram_sd;
        obs_ready = cmd_ready;
        m_idle    = (exp_q.size() == 0);
        exp_valid = 1'b0;
        if (chk_on) begin
            chk("ram_cs", 64'(ram_cs), 64'(pend_cs));
            if (pend_cs) begin
                chk("ram_addr", 64'(ram_addr), 64'(pend_addr));
                chk("ram_wem",  64'(ram_wem),  64'(pend_wem));
                chk("ram_din",  ram_din, pend_din);
            end
            exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc_no);
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
            if (exp_valid) chk("rsp_rdata", rsp_rdata, exp_q[0].data);
            chk("idle", 64'(idle), 64'(m_idle));
            chk("ram_ds", 64'(ram_ds), 64'd0);
            if (chk_ready) chk("cmd_ready", 64'(cmd_ready), 64'(exp_q.size() < 2));
        end
        if (ram_cs === 1'b1) begin
            if (ram_wem == 8'd0) nx_dout = sram[ram_addr[7:0]];
            else sram[ram_addr[7:0]] = merge(sram[ram_addr[7:0]], ram_din, ram_wem);
        end
        if (exp_valid && rsp_ready) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back('{data: cmd_read ? ref_mem[cmd_addr[7:0]] : 64'd0,
                              avail: cyc_no + 2});
            if (!cmd_read)
                ref_mem[cmd_addr[7:0]] = merge(ref_mem[cmd_addr[7:0]], cmd_wdata, cmd_wmask);
            pend_addr = cmd_addr;
            pend_wem  = cmd_read ? 8'd0 : cmd_wmask;
            pend_din  = cmd_wdata;
        end
        pend_cs  = acc;
        last_acc = acc;
        @(posedge clk);
        #1;
        cyc_no++;
        ram_dout = nx_dout;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, run;
        for (int i = 0; i < 256; i++) begin
            sram[i]    = {$urandom(), $urandom()};
            ref_mem[i] = sram[i];
        end
        sram[8'h10] = 64'hA5A5;
        ref_mem[8'h10] = 64'hA5A5;

        rst_n = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 16'h10;
        cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b1; sd_req = 1'b0; ram_dout = '0;
        chk_on = 1'b0; chk_ready = 1'b0; pend_cs = 1'b0;

        // Reset held with a pending command request
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_ram_cs",    64'(ram_cs),    64'd0);
        chk("rst_ram_addr",  64'(ram_addr),  64'd0);
        chk("rst_ram_wem",   64'(ram_wem),   64'd0);
        chk("rst_ram_din",   ram_din,        64'd0);
        chk("rst_ram_ls",    64'(ram_ls),    64'd0);
        chk("rst_ram_ds",    64'(ram_ds),    64'd0);
        chk("rst_ram_sd",    64'(ram_sd),    64'd0);
        chk("rst_idle",      64'(idle),      64'd1);
        @(posedge clk);
        #1;
        cyc_no++;

        // Single read of 0x10 returning 0xA5A5
        rst_n = 1'b1; chk_on = 1'b1; chk_ready = 1'b1;
        cyc();
        chk("rd_accept", 64'(last_acc), 64'd1);
        cmd_valid = 1'b0;
        repeat (4) cyc();

        // Four back-to-back reads under response back-pressure
        rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1; na = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_addr = 16'(16'h50 + na);
            cyc();
            if (last_acc) na++;
        end
        chk("bp_accepts", 64'(na), 64'd2);
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && na < 4; i++) begin
            cmd_addr = 16'(16'h50 + na);
            cyc();
            if (last_acc) na++;
        end
        chk("bp_all_accepted", 64'(na), 64'd4);
        cmd_valid = 1'b0;
        repeat (6) cyc();
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Partial-mask write then read-back
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 16'h20;
        cmd_wdata = 64'h1234; cmd_wmask = 8'h0F;
        cyc();
        chk("wr_accept", 64'(last_acc), 64'd1);
        cmd_valid = 1'b0;
        cyc();
        cmd_valid = 1'b1; cmd_read = 1'b1;
        cyc();
        chk("rb_accept", 64'(last_acc), 64'd1);
        cmd_valid = 1'b0;

        // Light sleep after 16 idle cycles, wake on a command
        chk_ready = 1'b0; run = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (m_idle && !cmd_valid) run++; else run = 0;
            if (run == 16) break;
        end
        chk("ls_run", 64'(run), 64'd16);
        chk("ls_before", 64'(obs_ls), 64'd0);
        cyc();
        chk("ls_enter", 64'(obs_ls), 64'd1);
        chk("ls_ready", 64'(obs_ready), 64'd0);
        cmd_valid = 1'b1; cmd_addr = 16'h30;
        cyc();
        chk("ls_wakereq_ls", 64'(obs_ls), 64'd1);
        chk("ls_wakereq_ready", 64'(obs_ready), 64'd0);
        cyc();
        chk("wake1_ls", 64'(obs_ls), 64'd0);
        chk("wake1_ready", 64'(obs_ready), 64'd0);
        cyc();
        chk("ls_post_accept", 64'(last_acc), 64'd1);
        cmd_valid = 1'b0; chk_ready = 1'b1;
        repeat (4) cyc();

        // Shutdown requested with one read outstanding
        cmd_valid = 1'b1; cmd_addr = 16'h40;
        cyc();
        chk("sd_rd_accept", 64'(last_acc), 64'd1);
        cmd_valid = 1'b0; sd_req = 1'b1; chk_ready = 1'b0;
        cyc();
        chk("sd_drain_ready", 64'(obs_ready), 64'd0);
        chk("sd_drain_sd1", 64'(obs_sd), 64'd0);
        cyc();
        chk("sd_drain_sd2", 64'(obs_sd), 64'd0);
        cyc();
        chk("sd_idle_sd", 64'(obs_sd), 64'd0);
        cmd_valid = 1'b1; cmd_addr = 16'h41;
        cyc();
        chk("sd_enter", 64'(obs_sd), 64'd1);
        chk("sd_ls", 64'(obs_ls), 64'd0);
        chk("sd_ready", 64'(obs_ready), 64'd0);
        sd_req = 1'b0;
        cyc();
        chk("sd_last", 64'(obs_sd), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("wake_sd", 64'(obs_sd), 64'd0);
            chk("wake_ready", 64'(obs_ready), 64'd0);
        end
        cyc();
        chk("sd_post_accept", 64'(last_acc), 64'd1);
        cmd_valid = 1'b0; chk_ready = 1'b1;
        repeat (4) cyc();

        // Reset with traffic outstanding drops it
        rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_addr = 16'h11;
        repeat (2) cyc();
        cmd_valid = 1'b0; rst_n = 1'b0; chk_on = 1'b0;
        cyc();
        rst_n = 1'b1; exp_q.delete(); pend_cs = 1'b0; chk_on = 1'b1; rsp_ready = 1'b1;
        cyc();
        chk("midrst_idle", 64'(m_idle), 64'd1);

        // Random mixed traffic
        for (int i = 0; i < 500; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_read  = $urandom_range(0, 1) != 0;
            cmd_addr  = 16'($urandom_range(0, 15));
            cmd_wdata = {$urandom(), $urandom()};
            cmd_wmask = 8'($urandom_range(0, 255));
            rsp_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) cyc();
        chk("final_drain", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
